// File: rtl/multdiv_unit_if.sv
// Operand/start/result bundle between the execute stage and the
// iterative multiply/divide unit.
interface multdiv_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA,
      output data_operandB,
      output ctrl_MULT,
      output ctrl_DIV,
      input  data_result,
      input  data_exception,
      input  data_resultRDY
   );

   modport slave (
      input  data_operandA,
      input  data_operandB,
      input  ctrl_MULT,
      input  ctrl_DIV,
      output data_result,
      output data_exception,
      output data_resultRDY
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: one product or quotient bit per clock,
// fixed WIDTH+1 cycle latency from start to the one-cycle ready pulse.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clock,
   input logic          ctrl_reset,
   multdiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             r_state;
   state_t             w_state_n;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_opa;
   logic [WIDTH-1:0]   r_opb;
   logic               r_neg;
   logic               r_ovf;
   logic [WIDTH-1:0]   r_result;
   logic               r_exc;
   logic               r_rdy;

   logic               w_start;
   logic               w_busy;
   logic               w_last;
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [2*WIDTH-1:0] w_addend;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_min;

   assign w_a     = bus.data_operandA;
   assign w_b     = bus.data_operandB;
   assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
   assign w_busy  = (r_state == MUL) || (r_state == DIV);
   assign w_last  = (r_cnt == CW'(WIDTH));
   assign w_mag_a = w_a[WIDTH-1] ? -w_a : w_a;
   assign w_mag_b = w_b[WIDTH-1] ? -w_b : w_b;
   assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};

   // The multiplier MSB carries negative weight in two's complement.
   assign w_addend = (r_cnt == CW'(WIDTH - 1)) ? -r_opa : r_opa;

   assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_opa[WIDTH-1:0]};
   assign w_quo   = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   always_comb begin
      w_state_n = r_state;
      if (bus.ctrl_MULT) begin
         w_state_n = MUL;
      end else if (bus.ctrl_DIV) begin
         w_state_n = DIV;
      end else begin
         case (r_state)
            MUL:     if (w_last) w_state_n = DONE;
            DIV:     if (w_last) w_state_n = DONE;
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_rdy   <= 1'b0;
         if (w_start) begin
            r_cnt <= '0;
            r_neg <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
            r_ovf <= (w_a == w_min) && (&w_b);
            if (bus.ctrl_MULT) begin
               r_acc <= '0;
               r_opa <= {{WIDTH{w_a[WIDTH-1]}}, w_a};
               r_opb <= w_b;
            end else begin
               // Low half of the accumulator shifts the dividend out.
               r_acc <= {{WIDTH{1'b0}}, w_mag_a};
               r_opa <= {{WIDTH{1'b0}}, w_mag_b};
               r_opb <= '0;
            end
         end else if (w_busy && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == MUL) begin
               if (r_opb[0]) r_acc <= r_acc + w_addend;
               r_opa <= r_opa << 1;
               r_opb <= r_opb >> 1;
            end else if (!w_diff[WIDTH]) begin
               r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
               r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
         end else if (w_busy) begin
            r_rdy <= 1'b1;
            if (r_state == MUL) begin
               r_result <= r_acc[WIDTH-1:0];
               r_exc    <= r_acc[2*WIDTH-1:WIDTH] != {WIDTH{r_acc[WIDTH-1]}};
            end else if (r_opa[WIDTH-1:0] == '0) begin
               r_result <= '0;
               r_exc    <= 1'b1;
            end else begin
               r_result <= w_quo;
               r_exc    <= r_ovf;
            end
         end
      end
   end

   assign bus.data_result    = r_result;
   assign bus.data_exception = r_exc;
   assign bus.data_resultRDY = r_rdy;
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed multiply/divide unit in the execute stage.
- Consumes the two operand words read from the register file (A and B read ports).
- Its result is later presented to the register-file write port as write-back data.
- Iterative: one partial-product or quotient bit per clock. The pipeline stalls while the unit is busy, using data_resultRDY as the release.

Parameters:
WIDTH, 32, operand/result width in bits; the counter is sized ceil(log2(WIDTH))+1 bits.

Ports:
clock  input  1  rising-edge clock
ctrl_reset  input  1  asynchronous active-high reset
data_operandA  input  WIDTH  multiplicand / dividend, two's complement (from register read port A)
data_operandB  input  WIDTH  multiplier / divisor, two's complement (from register read port B)
ctrl_MULT  input  1  single-cycle start pulse for a multiply
ctrl_DIV  input  1  single-cycle start pulse for a divide
data_result  output  WIDTH  product low word or quotient; goes to register write data
data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY
data_resultRDY  output  1  one-cycle pulse: result and exception valid

Behaviour:
- Clock, reset, asynchrony:
  - One clock; reset is asynchronous and active-high (clock, ctrl_reset).
  - ctrl_reset forces state IDLE, counter 0, all internal registers 0, and data_result=0, data_exception=0, data_resultRDY=0, immediately and independent of clock.
  - An operation in flight is discarded with no RDY pulse.
- States: IDLE, MUL, DIV, DONE.
- Start, sampled at rising edge k:
  - ctrl_MULT=1 latches both operands, clears the accumulator and counter, and goes to MUL.
  - ctrl_DIV=1 (with ctrl_MULT=0) does the same and goes to DIV.
  - Both high at once: treated as MULT.
  - A start is accepted in ANY state. A start while MUL/DIV is in progress aborts the current operation and restarts with the new operands; the aborted operation gives no RDY.
- Iteration:
  - Edges k+1 .. k+WIDTH perform one step each; the counter increments to WIDTH.
  - MUL: radix-2 signed shift-add (Booth recoding permitted) over a 2*WIDTH product register.
  - DIV: operate on magnitudes with restoring or non-restoring division; the sign is applied at the end.
- Completion, edge k+WIDTH+1 (33 for WIDTH=32):
  - Register data_result and data_exception, go to DONE, and assert data_resultRDY.
  - RDY is high for exactly one cycle. The next edge returns to IDLE and clears RDY.
  - data_result and data_exception HOLD their values until the next completion or reset.
- Latency is fixed at WIDTH+1 edges from the start sample to RDY, for every case, including exceptions.
- Multiply rules:
  - data_result = low WIDTH bits of the full signed product.
  - data_exception=1 iff the full 2*WIDTH product is not the sign-extension of its low WIDTH bits.
- Divide rules:
  - Signed; the quotient truncates toward zero; the remainder is not output.
  - Divisor 0: data_result=0, data_exception=1.
  - Dividend = most-negative value and divisor = -1: data_result = most-negative value (32'h80000000), data_exception=1.
  - Otherwise data_exception=0.
- Operand inputs are ignored except on the start edge; they may change freely while busy.
- ctrl_MULT/ctrl_DIV held high for several cycles restart the operation on each edge. The environment must pulse them for one cycle only.

Test Plan:
- Reset, then MULT A=7, B=-6 -> RDY exactly 33 edges after start, for one cycle; result 0xFFFFFFD6 (-42), exception 0; result still -42 ten cycles later.
- MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Then MULT A=0x80000000, B=1 -> result 0x80000000, exception 0.
- DIV A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0. DIV A=100, B=-10 -> result 0xFFFFFFF6 (-10).
- DIV A=5, B=0 -> result 0, exception 1 at edge 33. DIV A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- MULT 3*4 started, then at edge 10 a DIV 20/5 is started -> no RDY for the multiply; a single RDY 33 edges after the DIV start, with result 4.
- DIV started, ctrl_reset pulsed at cycle 15 between edges -> outputs go 0 immediately with no RDY. Then ctrl_MULT and ctrl_DIV high together with A=3, B=5 -> result 15 (multiply taken).
